// File: rtl/bubble_page_buffer.sv
// bubble_page_buffer: double-banked page store that serialises bit-pairs to a bubble memory.
// Optional build macro BUBBLE_OUT_INVERT_EN inverts bubble_out_odd/even (idle becomes 1/1).
`default_nettype none

module bubble_page_buffer #(
  parameter int unsigned PAGE_LENGTH = 1168
) (
  input  logic        master_clock,
  input  logic        power_good,
  input  logic        buffer_write_enable,
  input  logic [10:0] buffer_write_address,
  input  logic [1:0]  buffer_write_data,
  input  logic        load_done,
  input  logic        page_start,
  input  logic        shift_tick,
  output logic        bubble_out_odd,
  output logic        bubble_out_even,
  output logic        page_valid,
  output logic        write_bank_full,
  output logic        underrun_flag
);

  localparam logic [11:0] c_PAGE_LEN = 12'(PAGE_LENGTH);
  localparam logic [10:0] c_LAST_PTR = 11'(PAGE_LENGTH - 1);

  // Bank select is the top index bit: bank r_read_sel is read, its complement is written.
  logic [1:0]  r_mem [0:4095];
  logic        r_read_sel;
  logic [10:0] r_ptr;
  logic [1:0]  r_out;
  logic        r_page_valid;
  logic        r_full;
  logic        r_underrun;

  logic        w_write_hit;
  logic        w_swap;
  logic        w_underrun;
  logic        w_tick;
  logic [11:0] w_wr_idx;
  logic [11:0] w_rd_idx;
  logic [1:0]  w_rd_data;

  assign w_write_hit = buffer_write_enable && ({1'b0, buffer_write_address} < c_PAGE_LEN);
  assign w_swap      = page_start && (r_full || load_done);
  assign w_underrun  = page_start && !w_swap;
  assign w_tick      = shift_tick && !page_start;
  assign w_wr_idx    = {~r_read_sel, buffer_write_address};
  assign w_rd_idx    = {r_read_sel, r_ptr};
  assign w_rd_data   = r_mem[w_rd_idx];

  // Write index uses the pre-swap select, so a swap-cycle write lands in the outgoing write bank.
  always_ff @(posedge master_clock) begin
    if (w_write_hit) begin
      r_mem[w_wr_idx] <= buffer_write_data;
    end
  end

  always_ff @(posedge master_clock or negedge power_good) begin
    if (!power_good) begin
      r_read_sel   <= 1'b0;
      r_ptr        <= 11'd0;
      r_out        <= 2'b00;
      r_page_valid <= 1'b0;
      r_full       <= 1'b0;
      r_underrun   <= 1'b0;
    end else if (w_swap) begin
      r_read_sel   <= ~r_read_sel;
      r_ptr        <= 11'd0;
      r_out        <= 2'b00;
      r_page_valid <= 1'b1;
      r_full       <= 1'b0;
    end else if (w_underrun) begin
      r_underrun   <= 1'b1;
      r_page_valid <= 1'b0;
      r_out        <= 2'b00;
    end else begin
      if (load_done) begin
        r_full <= 1'b1;
      end
      if (w_tick) begin
        if (r_page_valid) begin
          r_out <= w_rd_data;
          r_ptr <= r_ptr + 11'd1;
          if (r_ptr == c_LAST_PTR) begin
            r_page_valid <= 1'b0;
          end
        end else begin
          r_out <= 2'b00;
        end
      end
    end
  end

`ifdef BUBBLE_OUT_INVERT_EN
  assign bubble_out_odd  = ~r_out[1];
  assign bubble_out_even = ~r_out[0];
`else
  assign bubble_out_odd  = r_out[1];
  assign bubble_out_even = r_out[0];
`endif

  assign page_valid      = r_page_valid;
  assign write_bank_full = r_full;
  assign underrun_flag   = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_bubble_page_buffer.sv
// tb_bubble_page_buffer: scoreboard bench with a page-level reference model of the buffer.
`default_nettype none

module tb_bubble_page_buffer;

  localparam int PL = 4;
`ifdef BUBBLE_OUT_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        power_good;
  logic        we;
  logic [10:0] waddr;
  logic [1:0]  wdata;
  logic        load_done;
  logic        page_start;
  logic        shift_tick;
  logic        odd, even, valid, full, underrun;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bubble_page_buffer #(.PAGE_LENGTH(PL)) dut (
    .master_clock        (clk),
    .power_good          (power_good),
    .buffer_write_enable (we),
    .buffer_write_address(waddr),
    .buffer_write_data   (wdata),
    .load_done           (load_done),
    .page_start          (page_start),
    .shift_tick          (shift_tick),
    .bubble_out_odd      (odd),
    .bubble_out_even     (even),
    .page_valid          (valid),
    .write_bank_full     (full),
    .underrun_flag       (underrun)
  );

  // Reference model: two page arrays, which one is playing, and where in it we are.
  logic [1:0] m_bank [2][PL];
  int         m_play;
  int         m_pos;
  logic       m_valid, m_full, m_underrun;
  logic [1:0] m_out;
  logic [4:0] exp_q[$];

  function automatic logic [4:0] model_view();
    return {m_out[1] ^ INV, m_out[0] ^ INV, m_valid, m_full, m_underrun};
  endfunction

  task automatic model_reset();
    m_play = 0; m_pos = 0; m_valid = 0; m_full = 0; m_underrun = 0; m_out = 2'b00;
  endtask

  task automatic model_step(input logic w, input logic [10:0] a, input logic [1:0] d,
                            input logic ld, input logic ps, input logic st);
    if (w && a < PL) m_bank[1 - m_play][a] = d;
    if (ps) begin
      if (m_full || ld) begin
        m_play = 1 - m_play; m_pos = 0; m_full = 0; m_valid = 1; m_out = 2'b00;
      end else begin
        m_underrun = 1; m_valid = 0; m_out = 2'b00;
      end
    end else begin
      if (ld) m_full = 1;
      if (st) begin
        if (m_valid) begin
          m_out = m_bank[m_play][m_pos];
          m_pos = m_pos + 1;
          if (m_pos == PL) m_valid = 0;
        end else begin
          m_out = 2'b00;
        end
      end
    end
  endtask

  task automatic cyc(input logic w, input logic [10:0] a, input logic [1:0] d,
                     input logic ld, input logic ps, input logic st);
    @(negedge clk); #1;
    we = w; waddr = a; wdata = d; load_done = ld; page_start = ps; shift_tick = st;
    @(posedge clk);
    model_step(w, a, d, ld, ps, st);
    exp_q.push_back(model_view());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 11'd0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic direct_chk(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {odd, even, valid, full, underrun};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: odd/even/valid/full/underrun got=%b want=%b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [4:0] e;
    logic [4:0] act;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {odd, even, valid, full, underrun};
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL scoreboard: odd/even/valid/full/underrun got=%b want=%b at %0t", act, e, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] pat [PL];
    power_good = 1'b0; we = 0; waddr = 0; wdata = 0; load_done = 0; page_start = 0; shift_tick = 0;
    for (int b = 0; b < 2; b++) for (int i = 0; i < PL; i++) m_bank[b][i] = 2'b00;
    model_reset();
    #1;
    direct_chk("reset_state", {INV, INV, 3'b000});
    repeat (2) @(posedge clk);
    @(negedge clk); power_good = 1'b1;

    // Page start with nothing loaded must underrun.
    cyc(0, 0, 0, 0, 1, 0);
    idle(1);

    // Known page 3,1,2,0 then playback with one extra tick.
    pat[0] = 2'b11; pat[1] = 2'b01; pat[2] = 2'b10; pat[3] = 2'b00;
    for (int i = 0; i < PL; i++) cyc(1, 11'(i), pat[i], 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < PL + 1; i++) cyc(0, 0, 0, 0, 0, 1);
    idle(1);

    // Load the other bank during playback, then page_start colliding with a tick.
    cyc(1, 11'd0, 2'b10, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 11'd0, 2'b01, 0, 0, 1);
    cyc(1, 11'd1, 2'b11, 0, 0, 1);
    cyc(1, 11'd2, 2'b00, 0, 0, 0);
    cyc(1, 11'd3, 2'b10, 0, 0, 1);
    cyc(1, 11'd6, 2'b11, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < PL + 1; i++) cyc(0, 0, 0, 0, 0, 1);

    // Randomised traffic including out-of-range write addresses.
    for (int n = 0; n < 600; n++) begin
      cyc(1'($urandom_range(0, 1)), 11'($urandom_range(0, 2 * PL - 1)), 2'($urandom),
          ($urandom_range(0, 99) < 6), ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 45));
    end

    // Asynchronous reset two pairs into a page.
    for (int i = 0; i < PL; i++) cyc(1, 11'(i), 2'(i + 1), 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    @(negedge clk); #1;
    we = 0; load_done = 0; page_start = 0; shift_tick = 0;
    #1;
    power_good = 1'b0;
    #1;
    direct_chk("async_reset_mid_page", {INV, INV, 3'b000});
    model_reset();
    @(posedge clk);
    exp_q.push_back(model_view());
    @(negedge clk); #1; power_good = 1'b1;

    // First page_start after reset underruns even though a page was loaded earlier.
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1);
    idle(2);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bubble_page_buffer.md
BUBBLE_PAGE_BUFFER -- requirements
Module: bubble_page_buffer

Interface
REQ-001 SHALL have parameter PAGE_LENGTH, default 1168, meaning bit-pairs per page (legal range 1..2048).
REQ-002 SHALL have port master_clock  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port power_good  input  1  asynchronous active-low reset.
REQ-004 SHALL have port buffer_write_enable  input  1  write strobe from loader, one pair per cycle.
REQ-005 SHALL have port buffer_write_address  input  11  bit-pair index within page.
REQ-006 SHALL have port buffer_write_data  input  2  bit1 = odd, bit0 = even.
REQ-007 SHALL have port load_done  input  1  single-cycle pulse: write bank complete.
REQ-008 SHALL have port page_start  input  1  single-cycle pulse: begin outputting a new page.
REQ-009 SHALL have port shift_tick  input  1  single-cycle pulse: advance one bit-pair.
REQ-010 SHALL have ports bubble_out_odd, bubble_out_even  output  1 each  registered serial data.
REQ-011 SHALL have port page_valid  output  1  read bank is being played out.
REQ-012 SHALL have port write_bank_full  output  1  write bank holds a completed page.
REQ-013 SHALL have port underrun_flag  output  1  sticky: page_start arrived with no completed page.

Function
REQ-014 SHALL hold two banks of 2048 x 2 bits; write bank is always the complement of read bank (read_sel).
REQ-015 SHALL store buffer_write_data into write bank at buffer_write_address when buffer_write_enable=1 and address < PAGE_LENGTH; addresses >= PAGE_LENGTH SHALL be ignored.
REQ-016 SHALL set write_bank_full on the cycle after load_done; load_done while already full SHALL leave it set (page overwritten in place).
REQ-017 On page_start with write_bank_full=1 (or load_done in same cycle) SHALL toggle read_sel, clear read pointer to 0, clear write_bank_full, set page_valid.
REQ-018 On page_start with no completed page SHALL set underrun_flag, clear page_valid, force both outputs idle.
REQ-019 On shift_tick with page_valid=1 SHALL drive outputs from read bank at read pointer, visible the cycle after the tick (1-cycle latency), and increment pointer.
REQ-020 After the pair at PAGE_LENGTH-1 is output SHALL clear page_valid; subsequent ticks SHALL drive idle (0/0) outputs.
REQ-021 shift_tick with page_valid=0 SHALL drive idle outputs and not move the pointer.
REQ-022 page_start and shift_tick in the same cycle: page_start SHALL win; tick ignored.
REQ-023 A write in the swap cycle SHALL target the bank that was the write bank before the swap.
REQ-024 Reads and writes SHALL never address the same bank except per REQ-023.

Reset
REQ-025 power_good=0 SHALL asynchronously clear read_sel, read pointer, page_valid, write_bank_full, underrun_flag, and drive outputs idle; memory contents undefined.
REQ-026 Reset mid-page SHALL abandon the page; the first page_start after reset SHALL underrun unless load_done has occurred since.

Configuration
REQ-027 Macro BUBBLE_OUT_INVERT_EN: when defined, bubble_out_odd/even SHALL be inverted (idle = 1/1, stored 1 output as 0); when undefined, outputs non-inverted (idle = 0/0). Status outputs unaffected.

Verification
REQ-028 Reset, then page_start -> underrun_flag=1, page_valid=0, outputs idle.
REQ-029 PAGE_LENGTH=4, write pairs 3,1,2,0 at addresses 0-3, load_done, page_start, 5 ticks -> outputs 11,01,10,00 one cycle after each tick, then 00; page_valid drops after the 4th pair.
REQ-030 Fill bank during playback, load_done, page_start with shift_tick same cycle -> swap occurs, pointer 0, first tick after outputs new page's address 0.
REQ-031 Write address 1200 with PAGE_LENGTH=1168 -> no memory change; readback of page unchanged.
REQ-032 Assert power_good=0 mid-page at pointer 2 -> outputs idle and flags cleared asynchronously, before next clock edge.
REQ-033 Build with BUBBLE_OUT_INVERT_EN, repeat REQ-029 -> outputs 00,10,01,11 then idle 11.
